trap_controller: RTL
====================

// Module: trap_controller
// PURPOSE
// - Sequences trap entry and MRET exit around the CSR file.
// - Arbitrates fault reports from decode, execute and memory stages, plus the external interrupt.
// - Pulses controlReset/mcause into the CSR file so it captures MCAUSE/MEPC.
// - Then holds fetch for a flush window and issues a single-cycle PC redirect.
// PARAMETERS
// - FLUSH_CYCLES  2  cycles spent in FLUSH before redirect; legal range >= 1
// PORTS
// - clock            in   1   system clock; all state on posedge
// - reset            in   1   synchronous, active-low
// - decodeFault      in   1   decode-stage fault valid
// - decodeFaultCause in   4   decode fault cause: 4'h2 illegal, 4'h3 ebreak, 4'hB ecall
// - executeFault     in   1   execute-stage fault, cause 4'h0 (instr misaligned)
// - memoryLoadFault  in   1   memory-stage load misaligned, cause 4'h4
// - memoryStoreFault in   1   memory-stage store misaligned, cause 4'h6
// - mretValid        in   1   MRET reached commit
// - interrupt        in   1   external interrupt request, level
// - mstatusMIE       in   1   global interrupt enable (MSTATUS bit 3)
// - trapVector       in   32  MTVEC value from CSR file
// - mepc             in   32  MEPC value from CSR file
// - controlReset     out  1   trap-entry strobe to CSR file; combinational, 1 cycle
// - mcause           out  4   cause code; valid when controlReset=1
// - mcauseInterrupt  out  1   1 = cause is an interrupt; valid with controlReset
// - pipelineFlush    out  1   kill all in-flight stage valids
// - fetchStall       out  1   hold fetch PC
// - redirectValid    out  1   load redirectPC into fetch; 1-cycle pulse
// - redirectPC       out  32  new fetch PC
// - trapActive       out  1   1 whenever state != IDLE
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - state=IDLE, counter=0, kind=TRAP, saved target=0.
//   - All outputs 0 while reset low and in IDLE with no requests.
//   - Reset mid-sequence aborts to IDLE; no redirect is issued.
// - States:
//   - IDLE: pipeline runs; accepts requests.
//   - FLUSH: pipelineFlush=1, fetchStall=1 for exactly FLUSH_CYCLES cycles; counter counts 0..FLUSH_CYCLES-1.
//   - REDIRECT: redirectValid=1, pipelineFlush=1, fetchStall=0 for 1 cycle, then IDLE.
// - Priority in IDLE, oldest stage first:
//   - memoryStoreFault (6) > memoryLoadFault (4) > executeFault (0) > decodeFault (cause) > mretValid > interrupt.
//   - interrupt is taken only when mstatusMIE=1.
// - Trap accepted in IDLE (cycle N):
//   - controlReset=1, mcause and mcauseInterrupt driven combinationally in cycle N, so the CSR file samples the stage PCs of N.
//   - pipelineFlush=1 in N.
//   - Target latched: trapVector & ~32'h3.
//   - Next state FLUSH.
// - Interrupt trap: mcause=4'hB, mcauseInterrupt=1.
// - MRET accepted in IDLE:
//   - controlReset=0; pipelineFlush=1 in N.
//   - Target latched = mepc & ~32'h3.
//   - Next state FLUSH.
// - Cycle counts: fault in N -> FLUSH in N+1..N+FLUSH_CYCLES -> redirectValid at N+FLUSH_CYCLES+1 -> IDLE in N+FLUSH_CYCLES+2.
// - All requests are ignored while trapActive=1 (the younger work is being flushed); no queuing.
// - Simultaneous requests: only the highest priority is taken. A fault alongside mretValid takes the fault; the MRET is flushed.
// - A level interrupt still asserted after return is re-taken in IDLE if mstatusMIE=1.
// - redirectPC: holds the latched target in REDIRECT, 0 otherwise.
// - Counter: width $clog2(FLUSH_CYCLES+1); never wraps; cleared on entry to FLUSH.
// CONFIGURATION
// - VECTORED_INTERRUPT_EN defined:
//   - Applies when trapVector[1:0]==2'b01 and the trap is an interrupt.
//   - Target = (trapVector & ~32'h3) + {26'd0, mcause, 2'b00}; synchronous exceptions still use the base.
// - VECTORED_INTERRUPT_EN undefined: all traps use trapVector & ~32'h3; mode bits are ignored.
// TESTING
// - executeFault=1 in IDLE, trapVector=32'h100:
//   - controlReset=1 and mcause=0 in the same cycle.
//   - fetchStall high for 2 cycles.
//   - redirectValid=1 with redirectPC=32'h100 on the 3rd cycle.
// - memoryStoreFault=1, decodeFault=1 (cause B), interrupt=1, mstatusMIE=1, all together -> mcause=6, mcauseInterrupt=0; one redirect only.
// - mretValid=1, mepc=32'h2002 -> controlReset stays 0; redirectPC=32'h2000 after the flush window.
// - interrupt=1, mstatusMIE=0 -> no action. Set mstatusMIE=1 -> mcause=B, mcauseInterrupt=1.
//   - With VECTORED_INTERRUPT_EN and trapVector=32'h101: redirectPC=32'h12C.
// - Abort and no-retrigger:
//   - reset=0 during FLUSH -> IDLE next cycle, redirectValid never asserts.
//   - decodeFault pulsed during FLUSH -> ignored; no second controlReset.

Source files
------------

// File: rtl/trap_controller.sv
// Trap entry / MRET exit sequencer: arbitrates faults and interrupts, strobes the CSR file,
// flushes the pipeline for FLUSH_CYCLES and issues one redirect. Option: VECTORED_INTERRUPT_EN.
module trap_controller #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        decodeFault,
    input  logic [3:0]  decodeFaultCause,
    input  logic        executeFault,
    input  logic        memoryLoadFault,
    input  logic        memoryStoreFault,
    input  logic        mretValid,
    input  logic        interrupt,
    input  logic        mstatusMIE,
    input  logic [31:0] trapVector,
    input  logic [31:0] mepc,
    output logic        controlReset,
    output logic [3:0]  mcause,
    output logic        mcauseInterrupt,
    output logic        pipelineFlush,
    output logic        fetchStall,
    output logic        redirectValid,
    output logic [31:0] redirectPC,
    output logic        trapActive
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   target;
    logic [31:0]   target_next;

    logic          take_trap;
    logic          take_mret;
    logic [3:0]    cause;
    logic          cause_irq;
    logic [31:0]   base;

    assign base = trapVector & ~32'h3;

    // Oldest stage wins; requests only considered in IDLE and out of reset.
    always_comb begin
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause     = 4'h0;
        cause_irq = 1'b0;
        if (state == IDLE && reset) begin
            priority case (1'b1)
                memoryStoreFault: begin
                    take_trap = 1'b1;
                    cause     = 4'h6;
                end
                memoryLoadFault: begin
                    take_trap = 1'b1;
                    cause     = 4'h4;
                end
                executeFault: begin
                    take_trap = 1'b1;
                    cause     = 4'h0;
                end
                decodeFault: begin
                    take_trap = 1'b1;
                    cause     = decodeFaultCause;
                end
                mretValid: begin
                    take_mret = 1'b1;
                end
                (interrupt & mstatusMIE): begin
                    take_trap = 1'b1;
                    cause     = 4'hB;
                    cause_irq = 1'b1;
                end
                default: begin
                    take_trap = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        target_next     = target;
        controlReset    = 1'b0;
        mcause          = 4'h0;
        mcauseInterrupt = 1'b0;
        pipelineFlush   = 1'b0;
        fetchStall      = 1'b0;
        redirectValid   = 1'b0;
        redirectPC      = 32'h0;
        unique case (state)
            IDLE: begin
                if (take_trap) begin
                    controlReset    = 1'b1;
                    mcause          = cause;
                    mcauseInterrupt = cause_irq;
                    pipelineFlush   = 1'b1;
                    target_next     = base;
`ifdef VECTORED_INTERRUPT_EN
                    if (cause_irq && trapVector[1:0] == 2'b01) begin
                        target_next = base + {26'd0, cause, 2'b00};
                    end
`endif
                    count_next      = '0;
                    state_next      = FLUSH;
                end else if (take_mret) begin
                    pipelineFlush = 1'b1;
                    target_next   = mepc & ~32'h3;
                    count_next    = '0;
                    state_next    = FLUSH;
                end
            end
            FLUSH: begin
                pipelineFlush = 1'b1;
                fetchStall    = 1'b1;
                if (count == LAST) begin
                    state_next = REDIRECT;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            REDIRECT: begin
                pipelineFlush = 1'b1;
                redirectValid = 1'b1;
                redirectPC    = target;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign trapActive = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            target <= 32'h0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            target <= target_next;
        end
    end

endmodule
